store_buffer: RTL and testbench

- FIFO of committed stores between the MEM stage and the data memory.
- Stores enqueue from MEM and drain one per cycle into the data memory write port whenever that port is not needed by a load.
- Loads probe the buffer combinationally and get either a full store-to-load forward or a stall request on partial overlap.
- Decouples store issue from memory port contention and keeps memory write order equal to program order.

---
 rtl/store_buffer_if.sv | 39 +++
 rtl/store_buffer.sv | 137 +++++++++++++
 tb/tb_store_buffer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Store buffer bus bundle.
// Groups every signal between the MEM stage, the data-memory write port and
// the store buffer. Clock and reset stay plain ports on the module.
//   enq*      : store enqueue handshake from MEM (enqReady returned)
//   load*     : load probe from MEM (forwardHit/forwardWord/loadStall returned)
//   mem*      : drain towards the data-memory write port
//   empty     : buffer holds no pending stores
// Modports: master = MEM stage / memory side, slave = store buffer.
interface store_buffer_if;
  logic        enqValid;
  logic        enqReady;
  logic [31:0] enqAddress;
  logic [1:0]  enqWriteType;
  logic [31:0] enqData;
  logic        loadActive;
  logic [31:0] loadAddress;
  logic [1:0]  loadSize;
  logic        forwardHit;
  logic [31:0] forwardWord;
  logic        loadStall;
  logic [31:0] memAddress;
  logic [1:0]  memWriteType;
  logic [31:0] memDataWrite;
  logic        empty;

  modport master (
    output enqValid, enqAddress, enqWriteType, enqData,
    output loadActive, loadAddress, loadSize,
    input  enqReady, forwardHit, forwardWord, loadStall,
    input  memAddress, memWriteType, memDataWrite, empty
  );

  modport slave (
    input  enqValid, enqAddress, enqWriteType, enqData,
    input  loadActive, loadAddress, loadSize,
    output enqReady, forwardHit, forwardWord, loadStall,
    output memAddress, memWriteType, memDataWrite, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: FIFO of committed stores between MEM and the data memory.
// Stores enqueue from MEM and drain one per cycle into the memory write port
// whenever no load occupies it. Loads probe the buffer combinationally and get
// either a full store-to-load forward or a stall on partial overlap.
// Ports:
//   clock  : system clock, all state updates on posedge
//   reset  : synchronous active-high reset, discards pending stores
//   bus    : store_buffer_if.slave (enqueue, load probe, drain, empty)
// Write types: 0 = disabled, 1 = byte, 2 = half-word, 3 = word.
module store_buffer #(
  parameter int DEPTH    = 4,
  parameter int PTR_BITS = $clog2(DEPTH)
) (
  input logic           clock,
  input logic           reset,
  store_buffer_if.slave bus
);

  localparam logic [1:0] WRITE_DISABLED = 2'd0;
  localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(DEPTH);

  // Byte lanes touched by an access of the given size at byte offset lo.
  function automatic logic [3:0] lane_mask(input logic [1:0] lo, input logic [1:0] size);
    case (size)
      2'd1:    lane_mask = 4'b0001 << lo;
      2'd2:    lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      2'd3:    lane_mask = 4'hF;
      default: lane_mask = 4'h0;
    endcase
  endfunction

  // Move low-aligned store data into its word byte lanes.
  function automatic logic [31:0] lane_align(input logic [31:0] data, input logic [1:0] lo,
                                             input logic [1:0] size);
    case (size)
      2'd1:    lane_align = {24'd0, data[7:0]} << {lo, 3'b000};
      2'd2:    lane_align = lo[1] ? {data[15:0], 16'd0} : {16'd0, data[15:0]};
      2'd3:    lane_align = data;
      default: lane_align = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] expand_mask(input logic [3:0] m);
    expand_mask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  logic [31:0]       addr_q  [DEPTH];
  logic [1:0]        wtype_q [DEPTH];
  logic [31:0]       data_q  [DEPTH];
  logic [PTR_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_BITS:0]   count_q, count_d;

  logic enq_fire;
  logic drain;

  assign bus.enqReady = (count_q != FULL_COUNT);
  assign bus.empty    = (count_q == '0);
  assign enq_fire     = bus.enqValid && bus.enqReady && (bus.enqWriteType != WRITE_DISABLED);
  // The reset cycle must never issue a memory write.
  assign drain        = (count_q != '0) && !bus.loadActive && !reset;

  always_comb begin
    bus.memAddress   = 32'd0;
    bus.memWriteType = WRITE_DISABLED;
    bus.memDataWrite = 32'd0;
    if (drain) begin
      bus.memAddress   = addr_q[head_q];
      bus.memWriteType = wtype_q[head_q];
      bus.memDataWrite = data_q[head_q];
    end
  end

  always_comb begin
    head_d  = head_q + PTR_BITS'(drain);
    tail_d  = tail_q + PTR_BITS'(enq_fire);
    count_d = count_q;
    case ({enq_fire, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Walk from the youngest entry (tail-1) towards the head; the first
  // overlapping entry alone decides between forward and stall.
  logic [3:0]          load_mask;
  logic [3:0]          ent_mask;
  logic [PTR_BITS-1:0] idx;
  logic                found;

  always_comb begin
    load_mask       = lane_mask(bus.loadAddress[1:0], bus.loadSize);
    ent_mask        = 4'h0;
    idx             = '0;
    found           = 1'b0;
    bus.forwardHit  = 1'b0;
    bus.loadStall   = 1'b0;
    bus.forwardWord = 32'd0;
    for (int k = 1; k <= DEPTH; k++) begin
      idx      = tail_q - PTR_BITS'(k);
      ent_mask = lane_mask(addr_q[idx][1:0], wtype_q[idx]);
      if (!found && bus.loadActive && ((PTR_BITS+1)'(k) <= count_q) &&
          (addr_q[idx][31:2] == bus.loadAddress[31:2]) && ((ent_mask & load_mask) != 4'h0)) begin
        found = 1'b1;
        if ((ent_mask & load_mask) == load_mask) begin
          bus.forwardHit  = 1'b1;
          bus.forwardWord = lane_align(data_q[idx], addr_q[idx][1:0], wtype_q[idx]) &
                            expand_mask(load_mask);
        end else begin
          bus.loadStall = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload carries no reset; validity comes from head/count only.
  always_ff @(posedge clock) begin
    if (enq_fire) begin
      addr_q[tail_q]  <= bus.enqAddress;
      wtype_q[tail_q] <= bus.enqWriteType;
      data_q[tail_q]  <= bus.enqData;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam logic [1:0] WB = 2'd1, WH = 2'd2, WW = 2'd3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  store_buffer_if sbif();

  store_buffer #(.DEPTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (sbif)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  wt;
    logic [31:0] data;
  } st_t;

  typedef struct {
    logic        act;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        hit;
    logic        stall;
    logic [31:0] word;
  } probe_t;

  st_t    sbq[$];
  probe_t tbl[13];
  int     total = 0;
  int     passed = 0;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic enq(input logic [31:0] a, input logic [1:0] wt, input logic [31:0] d);
    st_t e;
    sbif.enqValid     = 1'b1;
    sbif.enqAddress   = a;
    sbif.enqWriteType = wt;
    sbif.enqData      = d;
    #1;
    if (sbif.enqReady && wt != 2'd0) begin
      e.addr = a; e.wt = wt; e.data = d;
      sbq.push_back(e);
    end
    tick();
    sbif.enqValid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (!sbif.empty && n < 20) begin
      tick();
      n++;
    end
    chk(name, 66'(sbif.empty), 66'd1);
  endtask

  // Every drained write must match the oldest outstanding accepted store.
  always @(negedge clock) begin
    st_t e;
    if (sbif.memWriteType != 2'd0) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL drain_unexpected: got write type %0d addr %h, required no write",
                 sbif.memWriteType, sbif.memAddress);
      end else begin
        e = sbq.pop_front();
        chk("drain_order", {sbif.memWriteType, sbif.memAddress, sbif.memDataWrite},
            {e.wt, e.addr, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Buffer for the table (oldest first): W 0x200=11223344, B 0x300=AB,
    // W 0x400=01020304, B 0x400=FF.
    tbl[0]  = '{1'b1, 32'h202, 2'd1, 1'b1, 1'b0, 32'h00220000};
    tbl[1]  = '{1'b1, 32'h202, 2'd2, 1'b1, 1'b0, 32'h11220000};
    tbl[2]  = '{1'b1, 32'h200, 2'd3, 1'b1, 1'b0, 32'h11223344};
    tbl[3]  = '{1'b1, 32'h203, 2'd1, 1'b1, 1'b0, 32'h11000000};
    tbl[4]  = '{1'b1, 32'h300, 2'd3, 1'b0, 1'b1, 32'h00000000};
    tbl[5]  = '{1'b1, 32'h300, 2'd1, 1'b1, 1'b0, 32'h000000AB};
    tbl[6]  = '{1'b1, 32'h301, 2'd1, 1'b0, 1'b0, 32'h00000000};
    tbl[7]  = '{1'b1, 32'h400, 2'd2, 1'b0, 1'b1, 32'h00000000};
    tbl[8]  = '{1'b1, 32'h400, 2'd1, 1'b1, 1'b0, 32'h000000FF};
    tbl[9]  = '{1'b1, 32'h401, 2'd1, 1'b1, 1'b0, 32'h00000300};
    tbl[10] = '{1'b1, 32'h402, 2'd2, 1'b1, 1'b0, 32'h01020000};
    tbl[11] = '{1'b1, 32'h204, 2'd3, 1'b0, 1'b0, 32'h00000000};
    tbl[12] = '{1'b0, 32'h202, 2'd1, 1'b0, 1'b0, 32'h00000000};

    sbif.enqValid = 1'b0; sbif.enqAddress = '0; sbif.enqWriteType = '0; sbif.enqData = '0;
    sbif.loadActive = 1'b0; sbif.loadAddress = '0; sbif.loadSize = '0;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("reset_outputs", {sbif.enqReady, sbif.empty, sbif.memWriteType, sbif.forwardHit, sbif.loadStall},
        {1'b1, 1'b1, 2'd0, 1'b0, 1'b0});
    chk("reset_mem_bus", {sbif.memAddress, sbif.memDataWrite}, 66'd0);
    chk("reset_fwd_word", 66'(sbif.forwardWord), 66'd0);

    // Single word store and drain latency
    sbif.enqValid = 1'b1;
    #1 chk("enq_ready_idle", 66'(sbif.enqReady), 66'd1);
    enq(32'h100, WW, 32'hDEADBEEF);
    chk("first_drain", {sbif.memWriteType, sbif.memAddress, sbif.memDataWrite}, {WW, 32'h100, 32'hDEADBEEF});
    tick();
    chk("empty_after_drain", 66'(sbif.empty), 66'd1);

    // Fill while a load blocks the port, then drain in order
    sbif.loadActive = 1'b1;
    for (int i = 0; i < 4; i++) enq(32'h500 + 32'(4*i), WW, 32'hA0 + 32'(i));
    chk("full_not_ready", 66'(sbif.enqReady), 66'd0);
    enq(32'h600, WW, 32'hBAD);
    chk("still_full", {sbif.enqReady, sbif.memWriteType}, 66'd0);
    sbif.loadActive = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain_seq", {sbif.memWriteType, sbif.memAddress}, {WW, 32'h500 + 32'(4*i)});
      tick();
    end
    chk("empty_after_fifo", 66'(sbif.empty), 66'd1);

    // Enqueue and drain together at count = DEPTH-1
    sbif.loadActive = 1'b1;
    for (int i = 0; i < 3; i++) enq(32'h700 + 32'(4*i), WH, 32'h1000 + 32'(i));
    sbif.loadActive = 1'b0;
    enq(32'h710, WB, 32'h5A);
    chk("enq_drain_same_cycle", {sbif.enqReady, sbif.empty}, {1'b1, 1'b0});
    tick(); tick(); tick();
    chk("empty_after_mixed", 66'(sbif.empty), 66'd1);

    // Lookup table against a full buffer
    sbif.loadActive = 1'b1;
    enq(32'h200, WW, 32'h11223344);
    enq(32'h300, WB, 32'h000000AB);
    enq(32'h400, WW, 32'h01020304);
    enq(32'h400, WB, 32'h000000FF);
    for (int i = 0; i < 13; i++) begin
      sbif.loadActive  = tbl[i].act;
      sbif.loadAddress = tbl[i].addr;
      sbif.loadSize    = tbl[i].size;
      #1 chk($sformatf("probe_%0d", i), {sbif.forwardHit, sbif.loadStall, sbif.forwardWord},
             {tbl[i].hit, tbl[i].stall, tbl[i].word});
      sbif.loadActive = 1'b1;
      tick();
    end
    sbif.loadActive = 1'b0;
    wait_empty("table_drained");

    // Partial overlap stalls until the drain removes it
    sbif.loadActive = 1'b1;
    enq(32'h300, WB, 32'h000000AB);
    sbif.loadAddress = 32'h300; sbif.loadSize = 2'd3;
    #1 chk("partial_stall", {sbif.forwardHit, sbif.loadStall}, {1'b0, 1'b1});
    sbif.loadActive = 1'b0;
    tick();
    sbif.loadActive = 1'b1;
    #1 chk("stall_cleared", {sbif.forwardHit, sbif.loadStall, sbif.forwardWord}, 66'd0);

    // Reset with a full buffer discards everything
    for (int i = 0; i < 4; i++) enq(32'h800 + 32'(4*i), WW, 32'hC0 + 32'(i));
    reset = 1'b1;
    sbif.loadActive = 1'b0;
    sbq.delete();
    #1 chk("no_write_in_reset", 66'(sbif.memWriteType), 66'd0);
    tick();
    reset = 1'b0;
    #1 chk("after_reset", {sbif.empty, sbif.enqReady, sbif.memWriteType}, {1'b1, 1'b1, 2'd0});
    tick();
    chk("no_write_after_reset", 66'(sbif.memWriteType), 66'd0);

    tick();
    chk("scoreboard_drained", 66'(sbq.size()), 66'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
